// File: rtl/mprj_io_cfg_loader.sv
// GPIO pad configuration store plus serial loader: shifts one word per pad out on two
// daisy chains, then strobes serial_load so every pad control block latches its word.
module mprj_io_cfg_loader #(
    parameter int unsigned TOTAL_PADS = 38,
    parameter int unsigned AREA1PADS  = 19,
    parameter int unsigned CFG_BITS   = 13,
    parameter int unsigned CLK_DIV    = 4
) (
    input  logic                wb_clk_i,
    input  logic                wb_rstn_i,
    input  logic                cfg_we,
    input  logic [5:0]          cfg_addr,
    input  logic [CFG_BITS-1:0] cfg_wdata,
    output logic [CFG_BITS-1:0] cfg_rdata,
    output logic                cfg_werr,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                serial_clock,
    output logic                serial_load,
    output logic                serial_data_1,
    output logic                serial_data_2
);

    localparam int unsigned AREA2PADS = TOTAL_PADS - AREA1PADS;
    localparam int unsigned NSTEPS    = (AREA1PADS > AREA2PADS) ? AREA1PADS : AREA2PADS;
    localparam int unsigned OFF1      = NSTEPS - AREA1PADS;
    localparam int unsigned OFF2      = NSTEPS - AREA2PADS;
    localparam int unsigned AW        = $clog2(TOTAL_PADS);
    localparam int unsigned SW        = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
    localparam int unsigned BW        = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
    localparam int unsigned PW        = $clog2(2 * CLK_DIV);

    localparam logic [CFG_BITS-1:0] RST_WORD   = CFG_BITS'(13'h0403);
    localparam logic [PW-1:0]       PHASE_LAST = PW'(2 * CLK_DIV - 1);
    localparam logic [PW-1:0]       LOAD_LAST  = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0]       PHASE_HIGH = PW'(CLK_DIV);
    localparam logic [BW-1:0]       BIT_LAST   = BW'(CFG_BITS - 1);
    localparam logic [SW-1:0]       STEP_LAST  = SW'(NSTEPS - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD, DONE} state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         phase_q, phase_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [SW-1:0]         step_q, step_d;
    logic [CFG_BITS-1:0]   store_q [TOTAL_PADS];
    logic [CFG_BITS-1:0]   rdata_q;
    logic                  werr_q;

    logic                  addr_ok, wr_ok;
    logic [AW-1:0]         addr_idx;
    logic [CFG_BITS-1:0]   word1, word2;
    logic [BW-1:0]         bsel;

    assign busy     = (state_q == SHIFT) || (state_q == LOAD);
    assign addr_ok  = 32'(cfg_addr) < TOTAL_PADS;
    assign addr_idx = cfg_addr[AW-1:0];
    assign wr_ok    = cfg_we && addr_ok && !busy;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) begin
            for (int unsigned i = 0; i < TOTAL_PADS; i++) store_q[i] <= RST_WORD;
            rdata_q <= '0;
            werr_q  <= 1'b0;
        end else begin
            if (wr_ok) store_q[addr_idx] <= cfg_wdata;
            rdata_q <= addr_ok ? store_q[addr_idx] : '0;
            werr_q  <= cfg_we && (!addr_ok || busy);
        end
    end

    assign cfg_rdata = rdata_q;
    assign cfg_werr  = werr_q;

    // Shorter chain is front-padded with zeros so its padding ends up at the chain tail.
    always_comb begin
        word1 = '0;
        word2 = '0;
        if (32'(step_q) >= OFF1) word1 = store_q[AW'(NSTEPS - 1 - 32'(step_q))];
        if (32'(step_q) >= OFF2) word2 = store_q[AW'(TOTAL_PADS - 1 + OFF2 - 32'(step_q))];
        bsel = BIT_LAST - bit_q;
    end

    assign serial_clock  = (state_q == SHIFT) && (phase_q >= PHASE_HIGH);
    assign serial_load   = (state_q == LOAD);
    assign serial_data_1 = (state_q == SHIFT) && word1[bsel];
    assign serial_data_2 = (state_q == SHIFT) && word2[bsel];
    assign done          = (state_q == DONE);

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) begin
            state_q <= IDLE;
            phase_q <= '0;
            bit_q   <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        step_d  = step_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    phase_d = '0;
                    bit_d   = '0;
                    step_d  = '0;
                end
            end
            SHIFT: begin
                if (phase_q == PHASE_LAST) begin
                    phase_d = '0;
                    if (bit_q == BIT_LAST) begin
                        bit_d = '0;
                        if (step_q == STEP_LAST) begin
                            step_d  = '0;
                            state_d = LOAD;
                        end else begin
                            step_d = step_q + 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            LOAD: begin
                if (phase_q == LOAD_LAST) begin
                    phase_d = '0;
                    state_d = DONE;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mprj_io_cfg_loader.sv
// Directed bench for mprj_io_cfg_loader: default-parameter instance plus a reduced one,
// expected chain bits queued per chain and popped at each serial_clock high phase.
module tb_mprj_io_cfg_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        a_we, a_werr, a_start, a_busy, a_done, a_sclk, a_load, a_d1, a_d2;
    logic [5:0]  a_addr;
    logic [12:0] a_wdata, a_rdata;
    logic        b_we, b_werr, b_start, b_busy, b_done, b_sclk, b_load, b_d1, b_d2;
    logic [5:0]  b_addr;
    logic [2:0]  b_wdata, b_rdata;

    mprj_io_cfg_loader u_a (
        .wb_clk_i(clk), .wb_rstn_i(rstn), .cfg_we(a_we), .cfg_addr(a_addr),
        .cfg_wdata(a_wdata), .cfg_rdata(a_rdata), .cfg_werr(a_werr), .start(a_start),
        .busy(a_busy), .done(a_done), .serial_clock(a_sclk), .serial_load(a_load),
        .serial_data_1(a_d1), .serial_data_2(a_d2)
    );

    mprj_io_cfg_loader #(.TOTAL_PADS(5), .AREA1PADS(2), .CFG_BITS(3), .CLK_DIV(1)) u_b (
        .wb_clk_i(clk), .wb_rstn_i(rstn), .cfg_we(b_we), .cfg_addr(b_addr),
        .cfg_wdata(b_wdata), .cfg_rdata(b_rdata), .cfg_werr(b_werr), .start(b_start),
        .busy(b_busy), .done(b_done), .serial_clock(b_sclk), .serial_load(b_load),
        .serial_data_1(b_d1), .serial_data_2(b_d2)
    );

    int          checks = 0;
    int          errors = 0;
    logic        q1[$];
    logic        q2[$];
    logic [12:0] mstore[38];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_a(input int addr, input logic [12:0] data, input logic exp_err);
        a_we = 1'b1; a_addr = 6'(addr); a_wdata = data;
        tick();
        a_we = 1'b0;
        check("werr", 32'(a_werr), 32'(exp_err));
        if (!exp_err) mstore[addr] = data;
    endtask

    task automatic rd_a(input int addr, input logic [12:0] exp);
        a_addr = 6'(addr);
        tick();
        check($sformatf("rdata[%0d]", addr), 32'(a_rdata), 32'(exp));
    endtask

    task automatic push_default();
        logic [12:0] w1, w2;
        for (int k = 0; k < 19; k++) begin
            w1 = mstore[18 - k];
            w2 = mstore[37 - k];
            for (int b = 12; b >= 0; b--) begin
                q1.push_back(w1[b]);
                q2.push_back(w2[b]);
            end
        end
    endtask

    task automatic run_seq(input bit sel, input int cd, input int nbits, input int exp_done,
                           input int restart_c, input int poke_c, input int abort_c);
        int   shape, done_c, shift_c, ph, stray;
        logic sclk, ld, bsy, dn, d1, d2, last1, last2, e1, e2;
        shape = 0; done_c = -1; shift_c = nbits * 2 * cd;
        last1 = 1'b0; last2 = 1'b0;
        if (sel) b_start = 1'b1; else a_start = 1'b1;
        tick();
        a_start = 1'b0; b_start = 1'b0; a_we = 1'b0; b_we = 1'b0;
        for (int c = 1; c <= exp_done + 2; c++) begin
            sclk = sel ? b_sclk : a_sclk;  ld = sel ? b_load : a_load;
            bsy  = sel ? b_busy : a_busy;  dn = sel ? b_done : a_done;
            d1   = sel ? b_d1   : a_d1;    d2 = sel ? b_d2   : a_d2;
            if (dn === 1'b1 && done_c < 0) done_c = c;
            if (abort_c != 0 && c == abort_c) begin
                rstn = 1'b0;
                tick();
                check("abort_outs", 32'({a_busy, a_done, a_sclk, a_load, a_d1, a_d2, a_werr}), 32'd0);
                check("abort_rdata", 32'(a_rdata), 32'd0);
                rstn = 1'b1;
                stray = 0;
                for (int i = 0; i < 40; i++) begin
                    tick();
                    if (a_load !== 1'b0 || a_done !== 1'b0 || a_busy !== 1'b0) stray++;
                end
                check("abort_quiet", 32'(stray), 32'd0);
                return;
            end
            if (c <= shift_c) begin
                ph = (c - 1) % (2 * cd);
                if (bsy !== 1'b1 || dn !== 1'b0 || ld !== 1'b0 || sclk !== (ph >= cd)) shape++;
                if (ph != 0 && (d1 !== last1 || d2 !== last2)) shape++;
                if (ph == cd) begin
                    e1 = (q1.size() > 0) ? q1.pop_front() : 1'bx;
                    e2 = (q2.size() > 0) ? q2.pop_front() : 1'bx;
                    check("chain1_bit", 32'(d1), 32'(e1));
                    check("chain2_bit", 32'(d2), 32'(e2));
                end
            end else if (c <= shift_c + cd) begin
                if (bsy !== 1'b1 || ld !== 1'b1 || sclk !== 1'b0 || d1 !== 1'b0 || d2 !== 1'b0 || dn !== 1'b0) shape++;
            end else begin
                if (bsy !== 1'b0 || ld !== 1'b0 || sclk !== 1'b0 || dn !== (c == shift_c + cd + 1)) shape++;
            end
            if (poke_c != 0 && c == poke_c + 1) check("werr_busy", 32'(a_werr), 32'd1);
            last1 = d1; last2 = d2;
            a_start = (!sel && c == restart_c);
            b_start = (sel && c == restart_c);
            a_we = (c == poke_c); a_addr = 6'd10; a_wdata = 13'h0AAA;
            tick();
        end
        a_start = 1'b0; b_start = 1'b0; a_we = 1'b0;
        check("done_cycle", 32'(done_c), 32'(exp_done));
        check("sb_empty", 32'(q1.size() + q2.size()), 32'd0);
        check("shape", 32'(shape), 32'd0);
    endtask

    initial begin
        logic [8:0] s1, s2;
        rstn = 1'b0;
        a_we = 1'b0; a_addr = '0; a_wdata = '0; a_start = 1'b0;
        b_we = 1'b0; b_addr = '0; b_wdata = '0; b_start = 1'b0;
        for (int i = 0; i < 38; i++) mstore[i] = 13'h0403;
        tick(); tick();
        check("reset_outs_a", 32'({a_busy, a_done, a_sclk, a_load, a_d1, a_d2, a_werr}), 32'd0);
        check("reset_rdata_a", 32'(a_rdata), 32'd0);
        check("reset_outs_b", 32'({b_busy, b_done, b_sclk, b_load, b_d1, b_d2, b_werr}), 32'd0);
        rstn = 1'b1;
        rd_a(5, 13'h0403);
        check("idle_busy", 32'(a_busy), 32'd0);

        // Main default-parameter load sequence
        wr_a(18, 13'h1FFF, 1'b0);
        wr_a(37, 13'h0001, 1'b0);
        rd_a(18, 13'h1FFF);
        push_default();
        run_seq(1'b0, 4, 247, 1981, 0, 0, 0);

        // Out-of-range write is rejected and leaves the store intact
        wr_a(40, 13'h1234, 1'b1);
        rd_a(40, 13'h0000);
        rd_a(37, 13'h0001);

        // start again at bit 30 is ignored; write during busy at bit 40 is rejected
        push_default();
        run_seq(1'b0, 4, 247, 1981, 30 * 8 + 1, 40 * 8 + 1, 0);
        rd_a(10, 13'h0403);

        // Reset at bit 100, then a full run with the reset words
        push_default();
        run_seq(1'b0, 4, 247, 1981, 0, 0, 100 * 8 + 1);
        q1.delete(); q2.delete();
        for (int i = 0; i < 38; i++) mstore[i] = 13'h0403;
        rd_a(18, 13'h0403);
        rd_a(37, 13'h0403);
        push_default();
        run_seq(1'b0, 4, 247, 1981, 0, 0, 0);

        // Reduced instance: pads 0..3 written first, pad 4 written in the start cycle
        for (int i = 0; i < 4; i++) begin
            b_we = 1'b1; b_addr = 6'(i); b_wdata = 3'(i + 1);
            tick();
            check("werr_b", 32'(b_werr), 32'd0);
        end
        b_we = 1'b1; b_addr = 6'd4; b_wdata = 3'd5;
        s1 = 9'b000_010_001;
        s2 = 9'b101_100_011;
        for (int i = 8; i >= 0; i--) begin
            q1.push_back(s1[i]);
            q2.push_back(s2[i]);
        end
        run_seq(1'b1, 1, 9, 20, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
